// File: rtl/lifo_stream_reverser.sv
// Frame reverser. It fills an external LIFO with one input frame and then
// drains the LIFO onto a registered output stream, so each frame comes out
// in reverse order. Words beyond the LIFO capacity are dropped and the drop
// is flagged on overflow_o.
module lifo_stream_reverser #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned POP_LATENCY = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  // input frame stream
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  // reversed output stream
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  // LIFO master side
  output logic                  push_o,
  output logic [DATA_WIDTH-1:0] push_data_o,
  output logic                  pop_o,
  input  logic [DATA_WIDTH-1:0] pop_data_i,
  input  logic                  lifo_empty_i,
  input  logic                  lifo_full_i,
  output logic                  overflow_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  ovf_q, ovf_d;
  logic                  sof_q, sof_d;            // next accepted beat starts a frame
  logic                  inflight_q, inflight_d;  // a pop was issued last cycle
  logic                  inflight_last_q, inflight_last_d;

  logic load_ok;
  logic m_hs;

  // The pushed-word counter is authoritative; the LIFO empty flag is redundant.
  logic unused_empty;
  assign unused_empty = lifo_empty_i;

  // Next-state and LIFO/stream control.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    m_valid_d       = m_valid_q;
    m_last_d        = m_last_q;
    m_data_d        = m_data_q;
    ovf_d           = ovf_q;
    sof_d           = sof_q;
    inflight_d      = inflight_q;
    inflight_last_d = inflight_last_q;
    s_ready_o       = 1'b0;
    push_o          = 1'b0;
    push_data_o     = s_data_i;
    pop_o           = 1'b0;

    load_ok = (~m_valid_q | m_ready_i) & (cnt_q != '0);
    m_hs    = m_valid_q & m_ready_i;

    unique case (state_q)
      StFill: begin
        s_ready_o = 1'b1;
        push_o    = s_valid_i & ~lifo_full_i;
        if (push_o) begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (s_valid_i) begin
          sof_d = s_last_i;
          if (lifo_full_i) begin
            ovf_d = 1'b1;
          end else if (sof_q) begin
            ovf_d = 1'b0;
          end
          if (s_last_i) begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        if (m_hs) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            m_last_d = 1'b0;
            state_d  = StFill;
          end
        end
        if (POP_LATENCY == 0) begin
          if (load_ok) begin
            pop_o     = 1'b1;
            m_data_d  = pop_data_i;
            m_valid_d = 1'b1;
            m_last_d  = (cnt_q == CntW'(1));
            cnt_d     = cnt_q - CntW'(1);
          end
        end else begin
          // Issuing only while nothing is in flight gives at most one
          // outstanding pop and therefore a two-cycle pop spacing.
          if (inflight_q) begin
            m_data_d   = pop_data_i;
            m_valid_d  = 1'b1;
            m_last_d   = inflight_last_q;
            inflight_d = 1'b0;
          end else if (load_ok) begin
            pop_o           = 1'b1;
            cnt_d           = cnt_q - CntW'(1);
            inflight_d      = 1'b1;
            inflight_last_d = (cnt_q == CntW'(1));
          end
        end
        // A frame whose every beat was dropped leaves nothing to drain.
        if ((cnt_q == '0) && !m_valid_q && !inflight_q) begin
          state_d = StFill;
        end
      end

      default: state_d = StFill;
    endcase

    if (reset_i) begin
      push_o = 1'b0;
      pop_o  = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= StFill;
      cnt_q           <= '0;
      m_valid_q       <= 1'b0;
      m_last_q        <= 1'b0;
      m_data_q        <= '0;
      ovf_q           <= 1'b0;
      sof_q           <= 1'b1;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      m_valid_q       <= m_valid_d;
      m_last_q        <= m_last_d;
      m_data_q        <= m_data_d;
      ovf_q           <= ovf_d;
      sof_q           <= sof_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign m_valid_o  = m_valid_q;
  assign m_last_o   = m_last_q;
  assign m_data_o   = m_data_q;
  assign overflow_o = ovf_q;

endmodule
